// File: rtl/pscan_pkg.sv
// pscan_pkg -- shared types and constants for the pattern scan arbiter.
//
// Contents:
//   arb_state_t : arbiter FSM states (IDLE -> SHIFT -> FLUSH -> DONE)
//   det_state_t : serial 1010 Moore detector states S0..S4
//                 (S0 = nothing seen, S1 = "1", S2 = "10", S3 = "101",
//                  S4 = "1010" complete)
//   PATTERN     : the searched bit pattern, first bit in PATTERN[3]
package pscan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FLUSH,
    ST_DONE
  } arb_state_t;

  typedef enum logic [2:0] {
    S0,
    S1,
    S2,
    S3,
    S4
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/pattern_det.sv
// pattern_det -- serial Moore detector for the bit pattern 1010.
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, detector returns to S0
//   clr     : synchronous clear to S0 (takes priority over in)
//   in      : serial input bit, one per clock
//   hit     : high while the detector sits in its match state S4
//
// Configuration macro PSCAN_OVERLAP_EN:
//   undefined : non-overlapping, after a match the search restarts from
//               scratch so no bit is shared between two matches
//   defined   : overlapping, after a match the trailing "10" is reused
module pattern_det
  import pscan_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic in,
  output logic hit
);

  det_state_t state;
  det_state_t next_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S0;
    end else if (clr) begin
      state <= S0;
    end else begin
      state <= next_state;
    end
  end

  // The fall-back states on a wrong bit are specific to 1010: a stray "1"
  // in S1 or S3 is itself the start of a new candidate, so we land in S1.
  always_comb begin
    next_state = S0;
    case (state)
      S0: next_state = (in == PATTERN[3]) ? S1 : S0;
      S1: next_state = (in == PATTERN[2]) ? S2 : S1;
      S2: next_state = (in == PATTERN[1]) ? S3 : S0;
      S3: next_state = (in == PATTERN[0]) ? S4 : S1;
`ifdef PSCAN_OVERLAP_EN
      // Behave as if sitting in S2: the trailing "10" starts the next match.
      S4: next_state = (in == PATTERN[1]) ? S3 : S0;
`else
      // Behave as if sitting in S0: the matched bits are consumed.
      S4: next_state = (in == PATTERN[3]) ? S1 : S0;
`endif
      default: next_state = S0;
    endcase
  end

  assign hit = (state == S4);

endmodule

// File: rtl/pattern_scan_arb.sv
// pattern_scan_arb -- round-robin arbiter sharing one serial 1010 detector
// among NREQ requesters. The granted requester's DW-bit word is captured and
// shifted MSB-first through the detector; the number of matches is reported
// with a one-cycle done pulse.
//
// Parameters:
//   NREQ : number of requesters (2..8)
//   DW   : bits per scanned word (8..32, even)
//
// Ports:
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   req       : per-requester scan request (level), bit i = requester i
//   data      : requester i word on data[i*DW +: DW]
//   gnt       : one-hot grant, held for the whole scan including DONE
//   busy      : high whenever the FSM is not IDLE
//   done      : one-cycle completion pulse
//   done_id   : index of the finished requester, valid with done
//   match_cnt : number of 1010 matches in the scanned word, valid with done
//
// Configuration macro PSCAN_OVERLAP_EN selects overlapping detection inside
// pattern_det; timing is identical either way.
module pattern_scan_arb
  import pscan_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      data,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [$clog2(NREQ)-1:0] done_id,
  output logic [$clog2(DW)-1:0]   match_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DW);

  arb_state_t    state;
  arb_state_t    next_state;
  logic [IW-1:0] prio;
  logic [IW-1:0] win_idx;
  logic          win_valid;
  int            rr_idx;
  logic [IW-1:0] cur_id;
  logic [DW-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] cnt;
  logic          det_clr;
  logic          hit;

  // Round-robin pick: scan from prio (one past the last winner) upward with
  // wrap-around; the first requesting index wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_idx = int'(prio) + k;
      if (rr_idx >= NREQ) begin
        rr_idx = rr_idx - NREQ;
      end
      if (!win_valid && req[IW'(rr_idx)]) begin
        win_valid = 1'b1;
        win_idx   = IW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // SHIFT presents DW bits; FLUSH gives the detector one extra cycle so a
  // match completed by the last bit is still seen in S4 and counted.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  next_state = win_valid ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: next_state = (bit_cnt == CW'(DW - 1)) ? ST_FLUSH : ST_SHIFT;
      ST_FLUSH: next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Grant, capture and counting datapath. Inputs are only looked at in IDLE,
  // so req/data activity during a scan has no effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt     <= '0;
      prio    <= '0;
      cur_id  <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            gnt     <= NREQ'(1) << win_idx;
            prio    <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            cur_id  <= win_idx;
            shreg   <= data[win_idx*DW +: DW];
            bit_cnt <= '0;
            cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (hit) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (hit) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          gnt <= '0;
        end
        default: begin
          gnt <= '0;
        end
      endcase
    end
  end

  // The detector is cleared on the grant edge so SHIFT starts from S0.
  assign det_clr = (state == ST_IDLE) && win_valid;

  pattern_det u_det (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (det_clr),
    .in      (shreg[DW-1]),
    .hit     (hit)
  );

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign done_id   = cur_id;
  assign match_cnt = cnt;

endmodule

// File: tb/tb_pattern_scan_arb.sv
// tb_pattern_scan_arb -- self-checking bench for pattern_scan_arb.
// The reference model picks winners round-robin from a pointer and counts
// 1010 occurrences by sliding a 4-bit window over the captured word.
// Honours PSCAN_OVERLAP_EN the same way as the design.
module tb_pattern_scan_arb;

  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int IW     = $clog2(NREQ);
  localparam int CW     = $clog2(DW);
  localparam int PERIOD = 10;
  localparam int LAT    = DW + 2;
`ifdef PSCAN_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic                 clk;
  logic                 reset_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   data;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        done_id;
  logic [CW-1:0]        match_cnt;

  int n_vectors;
  int n_miscompares;
  int rr_ptr;

  pattern_scan_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // Reference: number of 1010 occurrences read MSB-first.
  function automatic int ref_count(input logic [DW-1:0] w);
    int n;
    int i;
    n = 0;
    i = 0;
    while (i <= DW - 4) begin
      if (w[DW-1-i -: 4] == 4'b1010) begin
        n++;
        i += OVERLAP ? 1 : 4;
      end else begin
        i++;
      end
    end
    return n;
  endfunction

  // Reference: first requesting index at or after rr_ptr, with wrap.
  function automatic int rr_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // Called at a negedge in an IDLE cycle with inputs already set. Walks the
  // scan one negedge at a time until done (bounded), reporting what it saw.
  task automatic run_scan(input int drop_after, input bit scramble,
                          output int cycles, output logic [NREQ-1:0] first_gnt,
                          output bit stable, output logic [IW-1:0] id,
                          output logic [CW-1:0] cnt);
    cycles = 0;
    stable = 1'b1;
    first_gnt = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) first_gnt = gnt;
      else if (gnt !== first_gnt) stable = 1'b0;
      if (busy !== 1'b1) stable = 1'b0;
      if (done === 1'b1) break;
      if (cycles == drop_after) req = '0;
      if (scramble) begin
        req = NREQ'($urandom);
        for (int i = 0; i < NREQ; i++) data[i*DW +: DW] = DW'($urandom);
      end
    end
    id  = done_id;
    cnt = match_cnt;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req = '1;
    data = '1;
    repeat (3) @(negedge clk);
    n_vectors++; if (gnt !== '0) begin n_miscompares++; $display("[TB] FAIL reset gnt: got %b expected 0", gnt); end
    n_vectors++; if (busy !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    n_vectors++; if (done !== 1'b0) begin n_miscompares++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    n_vectors++; if (done_id !== '0) begin n_miscompares++; $display("[TB] FAIL reset done_id: got %0d expected 0", done_id); end
    n_vectors++; if (match_cnt !== '0) begin n_miscompares++; $display("[TB] FAIL reset match_cnt: got %0d expected 0", match_cnt); end
    reset_n = 1'b1;
    req = '0;
    rr_ptr = 0;
    repeat (2) @(negedge clk);
    n_vectors++; if (busy !== 1'b0) begin n_miscompares++; $display("[TB] FAIL idle busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_scans;
    logic [DW-1:0]   words [3];
    logic [NREQ-1:0] reqs  [3];
    int              drops [3];
    int              exp_w, exp_cnt, cycles;
    logic [NREQ-1:0] exp_gnt, g;
    logic [IW-1:0]   id;
    logic [CW-1:0]   cnt;
    bit              stable;
    words = '{8'hAA, 8'h0A, 8'hA5};
    reqs  = '{4'b0001, 4'b0010, 4'b0100};
    drops = '{0, 0, 2};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NREQ; i++) data[i*DW +: DW] = DW'($urandom);
      data[t*DW +: DW] = words[t];
      req = reqs[t];
      exp_w = rr_pick(req);
      exp_cnt = ref_count(data[exp_w*DW +: DW]);
      exp_gnt = '0;
      exp_gnt[exp_w] = 1'b1;
      rr_ptr = (exp_w + 1) % NREQ;
      run_scan(drops[t], 1'b0, cycles, g, stable, id, cnt);
      req = '0;
      n_vectors++; if (g !== exp_gnt) begin n_miscompares++; $display("[TB] FAIL single%0d gnt: got %b expected %b", t, g, exp_gnt); end
      n_vectors++; if (stable !== 1'b1) begin n_miscompares++; $display("[TB] FAIL single%0d gnt_hold: got %b expected 1", t, stable); end
      n_vectors++; if (cycles != LAT) begin n_miscompares++; $display("[TB] FAIL single%0d latency: got %0d expected %0d", t, cycles, LAT); end
      n_vectors++; if (id !== IW'(exp_w)) begin n_miscompares++; $display("[TB] FAIL single%0d done_id: got %0d expected %0d", t, id, exp_w); end
      n_vectors++; if (cnt !== CW'(exp_cnt)) begin n_miscompares++; $display("[TB] FAIL single%0d match_cnt: got %0d expected %0d", t, cnt, exp_cnt); end
      @(negedge clk);
      n_vectors++; if ({gnt, busy, done} !== '0) begin n_miscompares++; $display("[TB] FAIL single%0d after_done gnt/busy/done: got %b_%b_%b expected 0", t, gnt, busy, done); end
    end
  endtask

  task automatic test_back_to_back;
    int              exp_w, cycles;
    logic [NREQ-1:0] exp_gnt, g;
    logic [IW-1:0]   id;
    logic [CW-1:0]   cnt;
    bit              stable;
    time             t_prev, t_now;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rr_ptr = 0;
    req = '1;
    data = '0;
    t_prev = 0;
    for (int s = 0; s < 5; s++) begin
      exp_w = rr_pick(req);
      exp_gnt = '0;
      exp_gnt[exp_w] = 1'b1;
      rr_ptr = (exp_w + 1) % NREQ;
      run_scan(0, 1'b0, cycles, g, stable, id, cnt);
      t_now = $time;
      n_vectors++; if (g !== exp_gnt) begin n_miscompares++; $display("[TB] FAIL b2b%0d gnt: got %b expected %b", s, g, exp_gnt); end
      n_vectors++; if (id !== IW'(exp_w)) begin n_miscompares++; $display("[TB] FAIL b2b%0d done_id: got %0d expected %0d", s, id, exp_w); end
      n_vectors++; if (cnt !== '0) begin n_miscompares++; $display("[TB] FAIL b2b%0d match_cnt: got %0d expected 0", s, cnt); end
      if (s > 0) begin
        n_vectors++; if (t_now - t_prev != (LAT + 1) * PERIOD) begin n_miscompares++; $display("[TB] FAIL b2b%0d done_gap: got %0t expected %0d", s, t_now - t_prev, (LAT + 1) * PERIOD); end
      end
      t_prev = t_now;
      if (s == 4) req = '0;
      @(negedge clk);
      n_vectors++; if ({gnt, busy} !== '0) begin n_miscompares++; $display("[TB] FAIL b2b%0d idle gnt/busy: got %b_%b expected 0", s, gnt, busy); end
    end
  endtask

  task automatic test_mid_reset;
    int              cycles;
    logic [NREQ-1:0] g;
    logic [IW-1:0]   id;
    logic [CW-1:0]   cnt;
    bit              stable, saw_done;
    req = 4'b0001;
    data = '0;
    data[0 +: DW] = 8'hAA;
    repeat (4) @(negedge clk);
    n_vectors++; if (busy !== 1'b1) begin n_miscompares++; $display("[TB] FAIL midrst busy_before: got %b expected 1", busy); end
    reset_n = 1'b0;
    req = '0;
    #1;
    n_vectors++; if ({gnt, busy, done} !== '0) begin n_miscompares++; $display("[TB] FAIL midrst gnt/busy/done: got %b_%b_%b expected 0", gnt, busy, done); end
    saw_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 1) reset_n = 1'b1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_vectors++; if (saw_done !== 1'b0) begin n_miscompares++; $display("[TB] FAIL midrst done_pulse: got %b expected 0", saw_done); end
    rr_ptr = 0;
    req = 4'b0001;
    data[0 +: DW] = 8'h0A;
    rr_ptr = 1;
    run_scan(0, 1'b0, cycles, g, stable, id, cnt);
    req = '0;
    n_vectors++; if (g !== 4'b0001) begin n_miscompares++; $display("[TB] FAIL midrst_after gnt: got %b expected 0001", g); end
    n_vectors++; if (cycles != LAT) begin n_miscompares++; $display("[TB] FAIL midrst_after latency: got %0d expected %0d", cycles, LAT); end
    n_vectors++; if (cnt !== CW'(ref_count(8'h0A))) begin n_miscompares++; $display("[TB] FAIL midrst_after match_cnt: got %0d expected %0d", cnt, ref_count(8'h0A)); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int              exp_w, exp_cnt, cycles;
    logic [NREQ-1:0] exp_gnt, g;
    logic [IW-1:0]   id;
    logic [CW-1:0]   cnt;
    bit              stable;
    logic [DW-1:0]   alt;
    alt = {(DW/2){2'b10}};
    for (int t = 0; t < 24; t++) begin
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        data[i*DW +: DW] = ($urandom_range(0, 2) == 0) ? (alt ^ DW'(1 << $urandom_range(0, DW-1))) : DW'($urandom);
      end
      exp_w = rr_pick(req);
      exp_cnt = ref_count(data[exp_w*DW +: DW]);
      exp_gnt = '0;
      exp_gnt[exp_w] = 1'b1;
      rr_ptr = (exp_w + 1) % NREQ;
      run_scan(0, 1'b1, cycles, g, stable, id, cnt);
      n_vectors++; if (g !== exp_gnt) begin n_miscompares++; $display("[TB] FAIL rand%0d gnt: got %b expected %b", t, g, exp_gnt); end
      n_vectors++; if (stable !== 1'b1) begin n_miscompares++; $display("[TB] FAIL rand%0d gnt_hold: got %b expected 1", t, stable); end
      n_vectors++; if (cycles != LAT) begin n_miscompares++; $display("[TB] FAIL rand%0d latency: got %0d expected %0d", t, cycles, LAT); end
      n_vectors++; if (id !== IW'(exp_w)) begin n_miscompares++; $display("[TB] FAIL rand%0d done_id: got %0d expected %0d", t, id, exp_w); end
      n_vectors++; if (cnt !== CW'(exp_cnt)) begin n_miscompares++; $display("[TB] FAIL rand%0d match_cnt: got %0d expected %0d", t, cnt, exp_cnt); end
      @(negedge clk);
      n_vectors++; if ({gnt, busy} !== '0) begin n_miscompares++; $display("[TB] FAIL rand%0d idle gnt/busy: got %b_%b expected 0", t, gnt, busy); end
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    n_vectors = 0;
    n_miscompares = 0;
    rr_ptr = 0;
    reset_n = 1'b0;
    req = '0;
    data = '0;
    test_reset();
    test_single_scans();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
